// File: rtl/niu_sii_inb_req_checker.sv
// Inbound NIU->SII DMA request checker: header/payload FSM, lane parity,
// ordered/bypass queue occupancy model, saturating counters and sticky errors.
module niu_sii_inb_req_checker #(
    parameter int DATA_W    = 128,
    parameter int PAR_LANE  = 16,
    parameter int WR_BEATS  = 4,
    parameter int ORD_DEPTH = 16,
    parameter int BYP_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic                                 iol2clk,
    input  logic                                 rst_l,
    input  logic                                 chk_en,
    input  logic                                 err_clr,
    input  logic                                 niu_sii_hdr_vld,
    input  logic                                 niu_sii_reqbypass,
    input  logic                                 niu_sii_datareq,
    input  logic                                 niu_sii_datareq16,
    input  logic [DATA_W-1:0]                    niu_sii_data,
    input  logic [DATA_W/PAR_LANE-1:0]           niu_sii_parity,
    input  logic                                 sii_niu_oqdq,
    input  logic                                 sii_niu_bqdq,
    output logic [CNT_W-1:0]                     rd_cnt,
    output logic [CNT_W-1:0]                     wr_cnt,
    output logic [CNT_W-1:0]                     wr16_cnt,
    output logic [$clog2(ORD_DEPTH+1)-1:0]       ord_occ,
    output logic [$clog2(BYP_DEPTH+1)-1:0]       byp_occ,
    output logic                                 in_payload,
    output logic [7:0]                           err_vec,
    output logic                                 err_pulse
);

    localparam int LANES  = DATA_W / PAR_LANE;
    localparam int ORD_W  = $clog2(ORD_DEPTH + 1);
    localparam int BYP_W  = $clog2(BYP_DEPTH + 1);
    localparam int BEAT_W = $clog2(WR_BEATS + 1);

    localparam logic [ORD_W-1:0]  ORD_FULL = ORD_W'(ORD_DEPTH);
    localparam logic [BYP_W-1:0]  BYP_FULL = BYP_W'(BYP_DEPTH);
    localparam logic [BEAT_W-1:0] BEATS_64 = BEAT_W'(WR_BEATS);
    localparam logic [BEAT_W-1:0] BEATS_16 = BEAT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

    // ------------------------------------------------------------------
    // Per-lane parity
    // ------------------------------------------------------------------
    logic [LANES-1:0] lane_bad;
    logic             par_bad;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_par
            assign lane_bad[gi] = niu_sii_parity[gi] ^ (^niu_sii_data[gi*PAR_LANE +: PAR_LANE]);
        end
    endgenerate

    assign par_bad = |lane_bad;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: decode outputs (headers only decoded in IDLE with checking on)
    // ------------------------------------------------------------------
    logic hdr_seen, hdr_illegal, hdr_accept;
    logic acc_rd, acc_wr, acc_wr16;
    logic beat_seen, hdr_intrude;

    always_comb begin
        hdr_seen    = 1'b0;
        hdr_illegal = 1'b0;
        hdr_accept  = 1'b0;
        acc_rd      = 1'b0;
        acc_wr      = 1'b0;
        acc_wr16    = 1'b0;
        beat_seen   = 1'b0;
        hdr_intrude = 1'b0;
        if (chk_en) begin
            if (state_reg == IDLE) begin
                hdr_seen    = niu_sii_hdr_vld;
                hdr_illegal = niu_sii_hdr_vld & niu_sii_datareq16 & ~niu_sii_datareq;
                hdr_accept  = niu_sii_hdr_vld & (niu_sii_datareq | ~niu_sii_datareq16);
                acc_rd      = hdr_accept & ~niu_sii_datareq;
                acc_wr      = hdr_accept & niu_sii_datareq & ~niu_sii_datareq16;
                acc_wr16    = hdr_accept & niu_sii_datareq & niu_sii_datareq16;
            end else begin
                beat_seen   = 1'b1;
                hdr_intrude = niu_sii_hdr_vld;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        if (!chk_en) begin
            // Disabling checks abandons any payload silently
            state_next    = IDLE;
            beat_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (acc_wr) begin
                        state_next    = PAYLOAD;
                        beat_cnt_next = BEATS_64;
                    end else if (acc_wr16) begin
                        state_next    = PAYLOAD;
                        beat_cnt_next = BEATS_16;
                    end
                end
                PAYLOAD: begin
                    if (beat_cnt_reg == BEATS_16) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg - BEAT_W'(1);
                    end
                end
                default: begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end
            endcase
        end
    end

    assign in_payload = (state_reg == PAYLOAD);

    // ------------------------------------------------------------------
    // Queue occupancy model
    // ------------------------------------------------------------------
    logic             ord_inc, byp_inc;
    logic [ORD_W-1:0] ord_occ_reg, ord_occ_next;
    logic [BYP_W-1:0] byp_occ_reg, byp_occ_next;
    logic             ord_ovf, ord_unf, byp_ovf, byp_unf;

    assign ord_inc = hdr_accept & ~niu_sii_reqbypass;
    assign byp_inc = hdr_accept &  niu_sii_reqbypass;

    always_comb begin
        ord_occ_next = ord_occ_reg;
        ord_ovf      = 1'b0;
        ord_unf      = 1'b0;
        case ({ord_inc, sii_niu_oqdq})
            2'b10: begin
                if (ord_occ_reg == ORD_FULL) ord_ovf = 1'b1;
                else                         ord_occ_next = ord_occ_reg + ORD_W'(1);
            end
            2'b01: begin
                if (ord_occ_reg == '0) ord_unf = 1'b1;
                else                   ord_occ_next = ord_occ_reg - ORD_W'(1);
            end
            default: ord_occ_next = ord_occ_reg;
        endcase
    end

    always_comb begin
        byp_occ_next = byp_occ_reg;
        byp_ovf      = 1'b0;
        byp_unf      = 1'b0;
        case ({byp_inc, sii_niu_bqdq})
            2'b10: begin
                if (byp_occ_reg == BYP_FULL) byp_ovf = 1'b1;
                else                         byp_occ_next = byp_occ_reg + BYP_W'(1);
            end
            2'b01: begin
                if (byp_occ_reg == '0) byp_unf = 1'b1;
                else                   byp_occ_next = byp_occ_reg - BYP_W'(1);
            end
            default: byp_occ_next = byp_occ_reg;
        endcase
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            ord_occ_reg <= '0;
            byp_occ_reg <= '0;
        end else begin
            ord_occ_reg <= ord_occ_next;
            byp_occ_reg <= byp_occ_next;
        end
    end

    assign ord_occ = ord_occ_reg;
    assign byp_occ = byp_occ_reg;

    // ------------------------------------------------------------------
    // Sticky errors; a new error outranks a coincident clear
    // ------------------------------------------------------------------
    logic [7:0] err_set;
    logic [7:0] err_vec_reg, err_vec_next;
    logic       err_pulse_reg, err_pulse_next;

    assign err_set = {byp_unf & chk_en, byp_ovf, ord_unf & chk_en, ord_ovf,
                      beat_seen & par_bad, hdr_seen & par_bad, hdr_intrude, hdr_illegal};

    always_comb begin
        err_vec_next   = (err_clr ? 8'h00 : err_vec_reg) | err_set;
        err_pulse_next = |(err_vec_next & ~err_vec_reg);
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            err_vec_reg   <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_vec_reg   <= err_vec_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    assign err_vec   = err_vec_reg;
    assign err_pulse = err_pulse_reg;

    // ------------------------------------------------------------------
    // Saturating request counters: 0=read, 1=64B write, 2=16B write
    // ------------------------------------------------------------------
    logic [2:0] cnt_inc;
    assign cnt_inc = {acc_wr16, acc_wr, acc_rd};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge iol2clk or negedge rst_l) begin
                if (!rst_l) begin
                    cnt_reg <= '0;
                end else if (err_clr) begin
                    cnt_reg <= cnt_inc[gi] ? CNT_W'(1) : '0;
                end else if (cnt_inc[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign rd_cnt   = g_cnt[0].cnt_reg;
    assign wr_cnt   = g_cnt[1].cnt_reg;
    assign wr16_cnt = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_niu_sii_inb_req_checker.sv
// Scoreboard bench: directed scenarios plus random traffic, each cycle's
// expected outputs come from a transaction-level model and are checked by a monitor.
module tb_niu_sii_inb_req_checker;

    localparam int DATA_W   = 128;
    localparam int PAR_LANE = 16;
    localparam int LANES    = DATA_W / PAR_LANE;
    localparam int WR_BEATS = 4;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 4;      // small so saturation is reachable
    localparam int OCC_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              chk_en = 1'b0, err_clr = 1'b0;
    logic              hv = 1'b0, byp = 1'b0, dr = 1'b0, d16 = 1'b0, oq = 1'b0, bq = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic [LANES-1:0]  par = '0;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt, wr16_cnt;
    logic [OCC_W-1:0]  ord_occ, byp_occ;
    logic              in_payload, err_pulse;
    logic [7:0]        err_vec;

    always #5 clk = ~clk;

    niu_sii_inb_req_checker #(
        .DATA_W(DATA_W), .PAR_LANE(PAR_LANE), .WR_BEATS(WR_BEATS),
        .ORD_DEPTH(DEPTH), .BYP_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .iol2clk(clk), .rst_l(rst_l), .chk_en(chk_en), .err_clr(err_clr),
        .niu_sii_hdr_vld(hv), .niu_sii_reqbypass(byp), .niu_sii_datareq(dr),
        .niu_sii_datareq16(d16), .niu_sii_data(data), .niu_sii_parity(par),
        .sii_niu_oqdq(oq), .sii_niu_bqdq(bq),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .wr16_cnt(wr16_cnt),
        .ord_occ(ord_occ), .byp_occ(byp_occ), .in_payload(in_payload),
        .err_vec(err_vec), .err_pulse(err_pulse)
    );

    typedef struct packed {
        logic [CNT_W-1:0] rd;
        logic [CNT_W-1:0] wr;
        logic [CNT_W-1:0] wr16;
        logic [OCC_W-1:0] ord;
        logic [OCC_W-1:0] bypq;
        logic             inp;
        logic [7:0]       err;
        logic             pulse;
    } snap_t;

    int    vectors = 0;
    int    miscompares = 0;
    snap_t exp_q[$];

    // Reference model state: remaining payload beats, counts, occupancies
    int         m_beats, m_rd, m_wr, m_wr16, m_ord, m_byp;
    logic [7:0] m_err;
    logic       m_pulse;

    function automatic void model_reset();
        m_beats = 0; m_rd = 0; m_wr = 0; m_wr16 = 0; m_ord = 0; m_byp = 0;
        m_err = 8'h00; m_pulse = 1'b0;
    endfunction

    function automatic void q_step(inout int occ, input bit inc, input bit dq, input bit ce,
                                   output bit ovf, output bit unf);
        ovf = 1'b0;
        unf = 1'b0;
        if (inc && !dq) begin
            if (occ == DEPTH) ovf = ce;
            else              occ = occ + 1;
        end else if (dq && !inc) begin
            if (occ == 0) unf = ce;
            else          occ = occ - 1;
        end
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic void model_step(input bit h, input bit b, input bit w, input bit w16,
                                       input bit qo, input bit qb, input bit ce, input bit clr,
                                       input bit bad);
        logic [7:0] set = 8'h00;
        logic [7:0] old = m_err;
        bit acc = 1'b0, o_ovf, o_unf, b_ovf, b_unf;
        if (!ce) begin
            m_beats = 0;
        end else if (m_beats > 0) begin
            if (bad) set[3] = 1'b1;
            if (h)   set[1] = 1'b1;
            m_beats = m_beats - 1;
        end else if (h) begin
            if (bad) set[2] = 1'b1;
            if (w16 && !w) set[0] = 1'b1;
            else           acc = 1'b1;
        end
        q_step(m_ord, acc && !b, qo, ce, o_ovf, o_unf);
        q_step(m_byp, acc && b,  qb, ce, b_ovf, b_unf);
        set[4] = o_ovf; set[5] = o_unf; set[6] = b_ovf; set[7] = b_unf;
        if (clr) begin m_rd = 0; m_wr = 0; m_wr16 = 0; end
        if (acc) begin
            if (!w)       m_rd = sat(m_rd);
            else if (w16) begin m_wr16 = sat(m_wr16); m_beats = 1; end
            else          begin m_wr = sat(m_wr); m_beats = WR_BEATS; end
        end
        m_err   = (clr ? 8'h00 : m_err) | set;
        m_pulse = |(m_err & ~old);
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.rd = CNT_W'(m_rd); s.wr = CNT_W'(m_wr); s.wr16 = CNT_W'(m_wr16);
        s.ord = OCC_W'(m_ord); s.bypq = OCC_W'(m_byp); s.inp = (m_beats > 0);
        s.err = m_err; s.pulse = m_pulse;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.rd = rd_cnt; s.wr = wr_cnt; s.wr16 = wr16_cnt; s.ord = ord_occ; s.bypq = byp_occ;
        s.inp = in_payload; s.err = err_vec; s.pulse = err_pulse;
        return s;
    endfunction

    // Monitor: after every clock edge, compare DUT against the oldest expectation
    snap_t mon_e, mon_a;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = dut_snap();
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got rd=%0d wr=%0d w16=%0d ord=%0d byp=%0d inp=%0b err=%b pls=%0b | exp rd=%0d wr=%0d w16=%0d ord=%0d byp=%0d inp=%0b err=%b pls=%0b",
                         $time, mon_a.rd, mon_a.wr, mon_a.wr16, mon_a.ord, mon_a.bypq, mon_a.inp, mon_a.err, mon_a.pulse,
                         mon_e.rd, mon_e.wr, mon_e.wr16, mon_e.ord, mon_e.bypq, mon_e.inp, mon_e.err, mon_e.pulse);
            end
        end
    end

    task automatic expect_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else begin
            $display("check %s = %0d", name, act);
        end
    endtask

    // Drive one cycle at the falling edge and queue its expected result
    task automatic cycle(input bit h, input bit b, input bit w, input bit w16,
                         input bit qo, input bit qb, input logic [LANES-1:0] bad,
                         input bit ce, input bit clr);
        logic [DATA_W-1:0] d;
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        hv = h; byp = b; dr = w; d16 = w16; oq = qo; bq = qb;
        chk_en = ce; err_clr = clr; data = d;
        for (int i = 0; i < LANES; i++) par[i] = (^d[i*PAR_LANE +: PAR_LANE]) ^ bad[i];
        model_step(h, b, w, w16, qo, qb, ce, clr, bad != '0);
        exp_q.push_back(model_snap());
    endtask

    task automatic hdr(input bit b, input bit w, input bit w16);
        cycle(1'b1, b, w, w16, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask
    task automatic beat();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask
    task automatic clr_c();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rh, rb, rw, rw16, rqo, rqb, rce, rclr;
        logic [LANES-1:0] rbad;
        int enc;

        model_reset();
        repeat (3) @(posedge clk);
        #2;
        expect_val("reset all outputs", int'(dut_snap()), 0);
        @(negedge clk);
        rst_l = 1'b1;

        // Read header, then ordered dequeue
        hdr(1'b0, 1'b0, 1'b0); settle();
        expect_val("read rd_cnt", int'(rd_cnt), 1);
        expect_val("read ord_occ", int'(ord_occ), 1);
        expect_val("read err_vec", int'(err_vec), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0); settle();
        expect_val("oqdq ord_occ", int'(ord_occ), 0);

        // 64B write, 4 beats, back-to-back read
        clr_c();
        hdr(1'b1, 1'b1, 1'b0); settle();
        expect_val("wr64 in_payload hdr", int'(in_payload), 1);
        for (int k = 0; k < WR_BEATS; k++) begin
            beat(); settle();
            expect_val($sformatf("wr64 in_payload beat%0d", k + 1), int'(in_payload), (k < WR_BEATS - 1) ? 1 : 0);
        end
        hdr(1'b1, 1'b0, 1'b0); settle();
        expect_val("b2b wr_cnt", int'(wr_cnt), 1);
        expect_val("b2b rd_cnt", int'(rd_cnt), 1);
        expect_val("b2b err_vec", int'(err_vec), 0);

        // 16B write, one beat, header right after
        clr_c();
        hdr(1'b1, 1'b1, 1'b1); beat(); hdr(1'b1, 1'b0, 1'b0); settle();
        expect_val("wr16 wr16_cnt", int'(wr16_cnt), 1);
        expect_val("wr16 err_vec", int'(err_vec), 0);

        // Header intruding on beat 2
        clr_c();
        hdr(1'b1, 1'b1, 1'b0); beat();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); settle();
        expect_val("intrude err_vec[1]", int'(err_vec[1]), 1);
        expect_val("intrude err_pulse", int'(err_pulse), 1);
        expect_val("intrude rd_cnt", int'(rd_cnt), 0);
        beat(); settle();
        expect_val("intrude pulse drop", int'(err_pulse), 0);
        expect_val("intrude in_payload b3", int'(in_payload), 1);
        beat(); settle();
        expect_val("intrude in_payload b4", int'(in_payload), 0);

        // Lane-3 parity error on payload beat 3
        clr_c();
        hdr(1'b1, 1'b1, 1'b0); beat(); beat();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LANES'(8), 1'b1, 1'b0); settle();
        expect_val("par err_vec[3]", int'(err_vec[3]), 1);
        expect_val("par err_vec[2]", int'(err_vec[2]), 0);
        beat();

        // Ordered queue overflow, then the same header paired with a dequeue
        clr_c();
        for (int k = 0; k < DEPTH; k++) hdr(1'b0, 1'b0, 1'b0);
        hdr(1'b0, 1'b0, 1'b0); settle();
        expect_val("ovf ord_occ", int'(ord_occ), DEPTH);
        expect_val("ovf err_vec[4]", int'(err_vec[4]), 1);
        expect_val("ovf rd_cnt saturated", int'(rd_cnt), CNT_MAX);
        clr_c();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0); settle();
        expect_val("full+dq ord_occ", int'(ord_occ), DEPTH);
        expect_val("full+dq err_vec[4]", int'(err_vec[4]), 0);

        // Asynchronous reset in the middle of a payload
        hdr(1'b1, 1'b1, 1'b0); beat(); settle();
        rst_l = 1'b0;
        #1;
        expect_val("midreset all outputs", int'(dut_snap()), 0);
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        hdr(1'b0, 1'b0, 1'b0); settle();
        expect_val("post-reset rd_cnt", int'(rd_cnt), 1);
        expect_val("post-reset ord_occ", int'(ord_occ), 1);
        expect_val("post-reset in_payload", int'(in_payload), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rce  = ($urandom_range(0, 99) < 95);
            rh   = ($urandom_range(0, 99) < 45);
            enc  = $urandom_range(0, 9);
            rw   = (enc >= 5 && enc <= 8);
            rw16 = (enc >= 8);
            rb   = $urandom_range(0, 1);
            rqo  = ($urandom_range(0, 99) < 30);
            rqb  = ($urandom_range(0, 99) < 30);
            rclr = !rh && ($urandom_range(0, 99) < 3);
            rbad = '0;
            if ($urandom_range(0, 99) < 6 && !(rh && rce && m_beats > 0))
                rbad[$urandom_range(0, LANES - 1)] = 1'b1;
            cycle(rh, rb, rw, rw16, rqo, rqb, rbad, rce, rclr);
        end

        settle();
        settle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
